// File: rtl/ofdm_framer.sv
// OFDM frame assembler: loads a sync preamble over the config stream after reset,
// then emits endless frames of stored sync words followed by pass-through data words.
module ofdm_framer #(
  parameter int unsigned SYNC_LEN = 25,
  parameter int unsigned DATA_LEN = 450
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [31:0] s_axis_config_tdata,
  input  logic [3:0]  s_axis_config_tstrb,
  input  logic        s_axis_config_tlast,
  input  logic        s_axis_config_tvalid,
  output logic        s_axis_config_tready,
  input  logic [31:0] s_axis_data_tdata,
  input  logic [3:0]  s_axis_data_tstrb,
  input  logic        s_axis_data_tlast,
  input  logic        s_axis_data_tvalid,
  output logic        s_axis_data_tready,
  output logic [39:0] m_axis_data_tdata,
  output logic [4:0]  m_axis_data_tstrb,
  output logic        m_axis_data_tlast,
  output logic        m_axis_data_tvalid,
  input  logic        m_axis_data_tready
);

  localparam int unsigned SW = $clog2(SYNC_LEN);
  localparam int unsigned DW = $clog2(DATA_LEN);
  localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_LEN - 1);
  localparam logic [DW-1:0] DATA_LAST = DW'(DATA_LEN - 1);

  typedef enum logic [1:0] {S_LOAD, S_SYNC, S_DATA} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sidx_q, sidx_d;
  logic [DW-1:0] didx_q, didx_d;
  logic [33:0]   tdata_q, tdata_d;
  logic          tvalid_q, tvalid_d;
  logic          tlast_q, tlast_d;
  logic          armed_q;
  logic [31:0]   sync_ram [SYNC_LEN];

  logic advance, cfg_hs, data_hs;
  logic unused_inputs;

  assign unused_inputs = ^{s_axis_config_tstrb, s_axis_config_tlast,
                           s_axis_data_tstrb, s_axis_data_tlast};

  assign advance              = !tvalid_q || m_axis_data_tready;
  // armed_q keeps config ready low during reset without a combinational path from areset
  assign s_axis_config_tready = armed_q && (state_q == S_LOAD);
  assign s_axis_data_tready   = (state_q == S_DATA) && advance;
  assign cfg_hs               = s_axis_config_tvalid && s_axis_config_tready;
  assign data_hs              = s_axis_data_tvalid && s_axis_data_tready;

  assign m_axis_data_tdata  = {6'b0, tdata_q};
  assign m_axis_data_tstrb  = 5'h1F;
  assign m_axis_data_tlast  = tlast_q;
  assign m_axis_data_tvalid = tvalid_q;

  always_comb begin
    state_d  = state_q;
    sidx_d   = sidx_q;
    didx_d   = didx_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    unique case (state_q)
      S_LOAD: begin
        if (cfg_hs) begin
          if (sidx_q == SYNC_LAST) begin
            sidx_d  = '0;
            state_d = S_SYNC;
          end else begin
            sidx_d = sidx_q + 1'b1;
          end
        end
      end
      S_SYNC: begin
        if (advance) begin
          tdata_d  = {(sidx_q == '0), 1'b1, sync_ram[sidx_q]};
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          if (sidx_q == SYNC_LAST) begin
            sidx_d  = '0;
            state_d = S_DATA;
          end else begin
            sidx_d = sidx_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (data_hs) begin
          tdata_d  = {2'b00, s_axis_data_tdata};
          tvalid_d = 1'b1;
          tlast_d  = (didx_q == DATA_LAST);
          if (didx_q == DATA_LAST) begin
            didx_d  = '0;
            state_d = S_SYNC;
          end else begin
            didx_d = didx_q + 1'b1;
          end
        end else if (advance) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= S_LOAD;
      sidx_q   <= '0;
      didx_q   <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sidx_q   <= sidx_d;
      didx_q   <= didx_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      armed_q  <= 1'b1;
    end
  end

  // Preamble storage survives reset; only LOAD rewrites it.
  always_ff @(posedge aclk) begin
    if (cfg_hs) sync_ram[sidx_q] <= s_axis_config_tdata;
  end

endmodule

// File: tb/tb_ofdm_framer.sv
// Directed bench for ofdm_framer: preamble load, continuous frames, backpressure,
// source gaps and mid-frame reset, checked against an independent frame model.
module tb_ofdm_framer;
  localparam int SL = 25;
  localparam int DL = 450;
  localparam int FL = SL + DL;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] cfg_tdata = '0;
  logic        cfg_tvalid = 1'b0;
  logic        cfg_tready;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [39:0] m_tdata;
  logic [4:0]  m_tstrb;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [31:0] sync_mem [SL];
  int   out_k, dn, bubbles, gap_cnt;
  bit   bp_en, track_bub, seen_valid, stall_prev, gap_phase, gap_done, saw_drop;
  logic [41:0] prev_word;

  ofdm_framer #(.SYNC_LEN(SL), .DATA_LEN(DL)) dut (
    .aclk                 (aclk),
    .areset               (areset),
    .s_axis_config_tdata  (cfg_tdata),
    .s_axis_config_tstrb  (4'hF),
    .s_axis_config_tlast  (1'b0),
    .s_axis_config_tvalid (cfg_tvalid),
    .s_axis_config_tready (cfg_tready),
    .s_axis_data_tdata    (s_tdata),
    .s_axis_data_tstrb    (4'hF),
    .s_axis_data_tlast    (1'b0),
    .s_axis_data_tvalid   (s_tvalid),
    .s_axis_data_tready   (s_tready),
    .m_axis_data_tdata    (m_tdata),
    .m_axis_data_tstrb    (m_tstrb),
    .m_axis_data_tlast    (m_tlast),
    .m_axis_data_tvalid   (m_tvalid),
    .m_axis_data_tready   (m_tready)
  );

  always #5 aclk = ~aclk;

  function automatic logic [31:0] dword(input int n);
    logic [15:0] lo;
    lo = 16'(n);
    return {lo + 16'h1000, ~lo};
  endfunction

  // {tlast, tdata} expected for overall output word k since the last preamble load
  function automatic logic [40:0] exp_out(input int k);
    int p, f;
    p = k % FL;
    f = k / FL;
    if (p < SL) return {1'b0, 6'b0, (p == 0), 1'b1, sync_mem[p]};
    return {(p == FL - 1), 8'b0, dword(f * DL + p - SL)};
  endfunction

  task automatic cycle();
    if (gap_phase && !gap_done && dn == 600) begin
      gap_cnt  = 3;
      gap_done = 1'b1;
    end
    if (gap_cnt > 0) begin
      s_tvalid = 1'b0;
      m_tready = 1'b1;
    end else begin
      s_tvalid = 1'b1;
      m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    s_tdata = dword(dn);
    #1;
    if (stall_prev) begin
      checks++;
      assert ({m_tvalid, m_tlast, m_tdata} === prev_word) else begin
        failures++;
        $error("FAIL hold k=%0d observed=%h expected=%h", out_k, {m_tvalid, m_tlast, m_tdata}, prev_word);
      end
    end
    if (gap_cnt > 0 && !m_tvalid) saw_drop = 1'b1;
    if (track_bub && seen_valid && !m_tvalid) bubbles++;
    if (m_tvalid) seen_valid = 1'b1;
    if (m_tvalid && m_tready) begin
      checks++;
      assert ({m_tlast, m_tdata} === exp_out(out_k)) else begin
        failures++;
        $error("FAIL word k=%0d observed=%h expected=%h", out_k, {m_tlast, m_tdata}, exp_out(out_k));
      end
      out_k++;
    end
    if (s_tvalid && s_tready) dn++;
    stall_prev = m_tvalid && !m_tready;
    prev_word  = {m_tvalid, m_tlast, m_tdata};
    if (gap_cnt > 0) gap_cnt--;
    @(posedge aclk); #1;
  endtask

  task automatic run_until(input int target, input int budget);
    int c;
    c = 0;
    while (out_k < target && c < budget) begin
      cycle();
      c++;
    end
    checks++;
    assert (out_k == target) else begin
      failures++;
      $error("FAIL timeout observed=%0d expected=%0d", out_k, target);
    end
  endtask

  task automatic load_sync();
    int i, c;
    i = 0;
    c = 0;
    cfg_tvalid = 1'b1;
    s_tvalid   = 1'b1;
    s_tdata    = dword(0);
    m_tready   = 1'b1;
    while (i < SL && c < 100) begin
      cfg_tdata = sync_mem[i];
      #1;
      checks++;
      assert (s_tready === 1'b0) else begin
        failures++;
        $error("FAIL data_tready_load observed=%b expected=0", s_tready);
      end
      if (cfg_tready) i++;
      c++;
      @(posedge aclk); #1;
    end
    cfg_tvalid = 1'b0;
    checks++;
    assert (c == SL && i == SL) else begin
      failures++;
      $error("FAIL load_cycles observed=%0d/%0d expected=%0d/%0d", c, i, SL, SL);
    end
    checks++;
    assert ({cfg_tready, m_tvalid} === 2'b00) else begin
      failures++;
      $error("FAIL after_load observed=%b expected=00", {cfg_tready, m_tvalid});
    end
    stall_prev = 1'b0;
    out_k      = 0;
    dn         = 0;
  endtask

  initial begin
    for (int i = 0; i < SL; i++) sync_mem[i] = {16'(16'h7000 + i), 16'(16'h0100 * i + 5)};
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    assert ({cfg_tready, s_tready, m_tvalid, m_tlast, m_tdata, m_tstrb} === {4'b0, 40'b0, 5'h1F}) else begin
      failures++;
      $error("FAIL reset_out observed=%h expected=%h",
             {cfg_tready, s_tready, m_tvalid, m_tlast, m_tdata, m_tstrb}, {4'b0, 40'b0, 5'h1F});
    end
    areset = 1'b0;
    @(posedge aclk); #1;
    checks++;
    assert ({cfg_tready, s_tready, m_tvalid} === 3'b100) else begin
      failures++;
      $error("FAIL post_reset observed=%b expected=100", {cfg_tready, s_tready, m_tvalid});
    end

    load_sync();
    track_bub  = 1'b1;
    seen_valid = 1'b0;
    bubbles    = 0;
    run_until(FL, 1000);
    checks++;
    assert (bubbles == 0) else begin
      failures++;
      $error("FAIL bubbles observed=%0d expected=0", bubbles);
    end

    track_bub = 1'b0;
    bp_en     = 1'b1;
    gap_phase = 1'b1;
    run_until(2 * FL, 8000);
    checks++;
    assert (saw_drop == 1'b1) else begin
      failures++;
      $error("FAIL gap_drop observed=%b expected=1", saw_drop);
    end

    bp_en     = 1'b0;
    gap_phase = 1'b0;
    run_until(2 * FL + SL + 10, 200);
    areset   = 1'b1;
    m_tready = 1'b1;
    @(posedge aclk); #1;
    checks++;
    assert ({cfg_tready, s_tready, m_tvalid, m_tlast, m_tdata, m_tstrb} === {4'b0, 40'b0, 5'h1F}) else begin
      failures++;
      $error("FAIL midreset_out observed=%h expected=%h",
             {cfg_tready, s_tready, m_tvalid, m_tlast, m_tdata, m_tstrb}, {4'b0, 40'b0, 5'h1F});
    end
    areset = 1'b0;
    @(posedge aclk); #1;
    checks++;
    assert ({cfg_tready, s_tready, m_tvalid, m_tlast, m_tdata} === {1'b1, 43'b0}) else begin
      failures++;
      $error("FAIL midreset_release observed=%h expected=%h",
             {cfg_tready, s_tready, m_tvalid, m_tlast, m_tdata}, {1'b1, 43'b0});
    end

    for (int i = 0; i < SL; i++) sync_mem[i] = {16'(16'h3000 + 3 * i), 16'hBEEF ^ 16'(i)};
    load_sync();
    run_until(SL + 20, 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
